// File: rtl/mmcm_drp_pkg.sv
// Shared types and helpers for the MMCM DRP reconfiguration master.
package mmcm_drp_pkg;

   localparam int unsigned DRP_ADDR_W = 7;
   localparam int unsigned DRP_DATA_W = 16;

   typedef enum logic [3:0] {
      StIdle,
      StHoldRst,
      StRd,
      StRdWait,
      StWr,
      StWrWait,
      StNext,
      StRelease,
      StWaitLock
   } drp_state_t;

   // A set mask bit keeps the readback bit; a clear one takes the new data bit.
   function automatic logic [DRP_DATA_W-1:0] rmw(input logic [DRP_DATA_W-1:0] rd_data,
                                                 input logic [DRP_DATA_W-1:0] new_data,
                                                 input logic [DRP_DATA_W-1:0] mask);
      return (rd_data & mask) | (new_data & ~mask);
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level signal.
module sync2 #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/mmcm_drp_reconfig.sv
// MMCM DRP master: one read-modify-write per masked update, MMCM held in reset for the
// whole batch, done reported once the synchronized LOCKED is seen.
module mmcm_drp_reconfig
   import mmcm_drp_pkg::*;
#(
   parameter int unsigned DRDY_TIMEOUT = 255,
   parameter int unsigned LOCK_TIMEOUT = 65535,
   parameter int unsigned RST_HOLD     = 4
) (
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [DRP_ADDR_W-1:0] req_addr,
   input  logic [DRP_DATA_W-1:0] req_data,
   input  logic [DRP_DATA_W-1:0] req_mask,
   input  logic                  req_last,
   output logic [DRP_ADDR_W-1:0] drp_daddr,
   output logic                  drp_den,
   output logic                  drp_dwe,
   output logic [DRP_DATA_W-1:0] drp_di,
   input  logic [DRP_DATA_W-1:0] drp_do,
   input  logic                  drp_drdy,
   output logic                  mmcm_rst,
   input  logic                  mmcm_locked,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);
   localparam int unsigned DRDY_W = $clog2(DRDY_TIMEOUT + 1);
   localparam int unsigned LOCK_W = $clog2(LOCK_TIMEOUT + 1);

   drp_state_t            state_q, state_d;
   logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
   logic [DRDY_W-1:0]     drdy_cnt_q, drdy_cnt_d;
   logic [LOCK_W-1:0]     lock_cnt_q, lock_cnt_d;
   logic [DRP_ADDR_W-1:0] addr_q, addr_d;
   logic [DRP_DATA_W-1:0] data_q, data_d;
   logic [DRP_DATA_W-1:0] mask_q, mask_d;
   logic                  last_q, last_d;
   logic [DRP_ADDR_W-1:0] daddr_q, daddr_d;
   logic [DRP_DATA_W-1:0] di_q, di_d;
   logic                  rst_q, rst_d;
   logic                  busy_q, busy_d;
   logic                  error_q, error_d;
   logic                  ready_q, ready_d;
   logic                  locked_sync;
   logic                  accept;

   sync2 #(
      .RST_VAL(1'b0)
   ) u_locked_sync (
      .clk  (CLK),
      .rst_n(nRST),
      .d    (mmcm_locked),
      .q    (locked_sync)
   );

   assign accept    = req_valid & ready_q;
   assign req_ready = ready_q;
   assign drp_daddr = daddr_q;
   assign drp_di    = di_q;
   assign mmcm_rst  = rst_q;
   assign busy      = busy_q;
   assign error     = error_q;

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      drdy_cnt_d = drdy_cnt_q;
      lock_cnt_d = lock_cnt_q;
      addr_d     = addr_q;
      data_d     = data_q;
      mask_d     = mask_q;
      last_d     = last_q;
      daddr_d    = daddr_q;
      di_d       = di_q;
      rst_d      = rst_q;
      busy_d     = busy_q;
      error_d    = error_q;
      drp_den    = 1'b0;
      drp_dwe    = 1'b0;
      done       = 1'b0;

      case (state_q)
         StIdle: begin
            if (accept) begin
               addr_d     = req_addr;
               data_d     = req_data;
               mask_d     = req_mask;
               last_d     = req_last;
               error_d    = 1'b0;
               busy_d     = 1'b1;
               rst_d      = 1'b1;
               hold_cnt_d = HOLD_W'(RST_HOLD - 1);
               state_d    = StHoldRst;
            end
         end

         StHoldRst: begin
            if (hold_cnt_q == '0) begin
               daddr_d = addr_q;
               state_d = StRd;
            end else begin
               hold_cnt_d = hold_cnt_q - HOLD_W'(1);
            end
         end

         StRd: begin
            drp_den    = 1'b1;
            drdy_cnt_d = DRDY_W'(DRDY_TIMEOUT);
            state_d    = StRdWait;
         end

         StRdWait: begin
            if (drp_drdy) begin
               di_d    = rmw(drp_do, data_q, mask_q);
               state_d = StWr;
            end else if (drdy_cnt_q == '0) begin
               error_d = 1'b1;
               state_d = StRelease;
            end else begin
               drdy_cnt_d = drdy_cnt_q - DRDY_W'(1);
            end
         end

         StWr: begin
            drp_den    = 1'b1;
            drp_dwe    = 1'b1;
            drdy_cnt_d = DRDY_W'(DRDY_TIMEOUT);
            state_d    = StWrWait;
         end

         StWrWait: begin
            if (drp_drdy) begin
               state_d = last_q ? StRelease : StNext;
            end else if (drdy_cnt_q == '0) begin
               error_d = 1'b1;
               state_d = StRelease;
            end else begin
               drdy_cnt_d = drdy_cnt_q - DRDY_W'(1);
            end
         end

         // Within a batch the MMCM is already in reset, so go straight to the read.
         StNext: begin
            if (accept) begin
               addr_d  = req_addr;
               data_d  = req_data;
               mask_d  = req_mask;
               last_d  = req_last;
               error_d = 1'b0;
               daddr_d = req_addr;
               state_d = StRd;
            end
         end

         StRelease: begin
            lock_cnt_d = LOCK_W'(LOCK_TIMEOUT);
            state_d    = StWaitLock;
         end

         StWaitLock: begin
            if (locked_sync) begin
               done    = 1'b1;
               busy_d  = 1'b0;
               state_d = StIdle;
            end else if (lock_cnt_q == '0) begin
               error_d = 1'b1;
               busy_d  = 1'b0;
               state_d = StIdle;
            end else begin
               lock_cnt_d = lock_cnt_q - LOCK_W'(1);
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      // Every path into RELEASE, normal or timeout, lets the MMCM out of reset.
      if (state_d == StRelease) begin
         rst_d = 1'b0;
      end
      ready_d = (state_d == StIdle) || (state_d == StNext);
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q    <= StIdle;
         hold_cnt_q <= '0;
         drdy_cnt_q <= '0;
         lock_cnt_q <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         mask_q     <= '0;
         last_q     <= 1'b0;
         daddr_q    <= '0;
         di_q       <= '0;
         rst_q      <= 1'b0;
         busy_q     <= 1'b0;
         error_q    <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         drdy_cnt_q <= drdy_cnt_d;
         lock_cnt_q <= lock_cnt_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         mask_q     <= mask_d;
         last_q     <= last_d;
         daddr_q    <= daddr_d;
         di_q       <= di_d;
         rst_q      <= rst_d;
         busy_q     <= busy_d;
         error_q    <= error_d;
         ready_q    <= ready_d;
      end
   end

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// Bench for mmcm_drp_reconfig: a register-array MMCM model answers DRP accesses and
// directed/random batches are checked against a bitwise merge reference.
module tb_mmcm_drp_reconfig;

   localparam int unsigned DRDY_TO = 15;
   localparam int unsigned LOCK_TO = 31;
   localparam int unsigned HOLD    = 4;

   logic        CLK = 1'b0;
   logic        nRST = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [6:0]  req_addr = '0;
   logic [15:0] req_data = '0;
   logic [15:0] req_mask = '0;
   logic        req_last = 1'b0;
   logic [6:0]  drp_daddr;
   logic        drp_den;
   logic        drp_dwe;
   logic [15:0] drp_di;
   logic [15:0] drp_do = '0;
   logic        drp_drdy;
   logic        resp_drdy = 1'b0;
   logic        spur_drdy = 1'b0;
   logic        mmcm_rst;
   logic        mmcm_locked = 1'b0;
   logic        busy;
   logic        done;
   logic        error;

   assign drp_drdy = resp_drdy | spur_drdy;

   always #5 CLK = ~CLK;

   mmcm_drp_reconfig #(
      .DRDY_TIMEOUT(DRDY_TO),
      .LOCK_TIMEOUT(LOCK_TO),
      .RST_HOLD    (HOLD)
   ) dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .req_mask   (req_mask),
      .req_last   (req_last),
      .drp_daddr  (drp_daddr),
      .drp_den    (drp_den),
      .drp_dwe    (drp_dwe),
      .drp_di     (drp_di),
      .drp_do     (drp_do),
      .drp_drdy   (drp_drdy),
      .mmcm_rst   (mmcm_rst),
      .mmcm_locked(mmcm_locked),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   // ---------------- MMCM DRP model and protocol monitor ----------------
   typedef struct {
      logic [6:0]  addr;
      logic        we;
      logic [15:0] di;
      int          rst_run;
      time         t;
   } acc_t;

   acc_t        log_q[$];
   logic [15:0] mem [128];
   bit          mem_init = 0;
   int          lat = 3;
   bit          never = 0;
   int          cd = 0;
   logic [6:0]  pend_addr = '0;
   bit          pend_rd = 0;
   bit          prev_den = 0;
   int          rst_run = 0;
   int          den_cnt = 0;
   int          dwe_cnt = 0;
   int          done_cnt = 0;
   int          bad_rst_cnt = 0;
   int          consec_cnt = 0;
   int          dwe_alone_cnt = 0;

   always @(negedge CLK) begin
      if (!mem_init) begin
         for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
         mem[8]   = 16'hABCD;
         mem_init = 1;
      end
      resp_drdy = 1'b0;
      if (!nRST) begin
         cd       = 0;
         prev_den = 0;
         rst_run  = 0;
      end else begin
         if (done) done_cnt++;
         if (drp_dwe && !drp_den) dwe_alone_cnt++;
         if (drp_den) begin
            den_cnt++;
            if (drp_dwe) dwe_cnt++;
            if (!mmcm_rst) bad_rst_cnt++;
            if (prev_den) consec_cnt++;
            log_q.push_back('{drp_daddr, drp_dwe, drp_di, rst_run, $time});
            if (drp_dwe) mem[drp_daddr] = drp_di;
            pend_addr = drp_daddr;
            pend_rd   = !drp_dwe;
            cd        = never ? 0 : lat;
         end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               resp_drdy = 1'b1;
               if (pend_rd) drp_do = mem[pend_addr];
            end
         end
         prev_den = drp_den;
         rst_run  = mmcm_rst ? rst_run + 1 : 0;
      end
   end

   // ---------------- checking helpers ----------------
   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] merge(input logic [15:0] old_v, input logic [15:0] new_v,
                                         input logic [15:0] keep);
      logic [15:0] r;
      for (int b = 0; b < 16; b++) r[b] = keep[b] ? old_v[b] : new_v[b];
      return r;
   endfunction

   task automatic send(input logic [6:0] a, input logic [15:0] d, input logic [15:0] m,
                       input logic l);
      int n = 0;
      @(negedge CLK);
      req_valid = 1'b1;
      req_addr  = a;
      req_data  = d;
      req_mask  = m;
      req_last  = l;
      while (req_ready !== 1'b1 && n < 500) begin
         @(negedge CLK);
         n++;
      end
      chk("req_accept", req_ready, 1);
      @(negedge CLK);
      req_valid = 1'b0;
   endtask

   task automatic wait_rst_fall(input string tag);
      int m = 0;
      while (mmcm_rst !== 1'b0 && m < 2000) begin
         @(negedge CLK);
         m++;
      end
      chk({tag, "_rst_release"}, m < 2000, 1);
   endtask

   task automatic lock_done(input string tag);
      int n = 0;
      wait_rst_fall(tag);
      repeat (2) @(negedge CLK);
      mmcm_locked = 1'b1;
      do begin
         @(negedge CLK);
         n++;
      end while (done !== 1'b1 && n < 20);
      chk({tag, "_done_latency"}, n, 2);
      @(negedge CLK);
      chk({tag, "_busy_clear"}, busy, 0);
      mmcm_locked = 1'b0;
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_req_ready"}, req_ready, 0);
      chk({tag, "_daddr"}, drp_daddr, 0);
      chk({tag, "_den"}, drp_den, 0);
      chk({tag, "_dwe"}, drp_dwe, 0);
      chk({tag, "_di"}, drp_di, 0);
      chk({tag, "_mmcm_rst"}, mmcm_rst, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_error"}, error, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      logic [6:0]  addrs [3];
      logic [15:0] dat [3];
      logic [15:0] msk [3];
      logic [15:0] expv [3];
      int          base, dwe0, done0, bad0, cons0, den0, n;
      time         t0, t1;

      #1 nRST = 1'b0;
      repeat (3) @(negedge CLK);
      chk_outputs_zero("reset");
      nRST = 1'b1;
      @(negedge CLK);
      chk("ready_after_reset", req_ready, 1);

      // Single update: DO=ABCD, keep top nibble, take the rest from 0x1234.
      lat   = 3;
      base  = log_q.size();
      done0 = done_cnt;
      send(7'h08, 16'h1234, 16'hF000, 1'b1);
      lock_done("t1");
      repeat (2) @(negedge CLK);
      chk("t1_den_count", log_q.size() - base, 2);
      chk("t1_rd_addr", log_q[base].addr, 7'h08);
      chk("t1_rd_we", log_q[base].we, 0);
      chk("t1_rst_hold", log_q[base].rst_run >= HOLD, 1);
      chk("t1_wr_addr", log_q[base+1].addr, 7'h08);
      chk("t1_wr_we", log_q[base+1].we, 1);
      chk("t1_wr_di", log_q[base+1].di, 16'hA234);
      chk("t1_done_pulses", done_cnt - done0, 1);
      chk("t1_error", error, 0);

      // Three-update batch with random data/masks and random DRDY latency.
      addrs[0] = 7'h08;
      addrs[1] = 7'h09;
      addrs[2] = 7'h4E;
      for (int i = 0; i < 3; i++) begin
         dat[i]  = 16'($urandom);
         msk[i]  = 16'($urandom);
         expv[i] = merge(mem[addrs[i]], dat[i], msk[i]);
      end
      lat   = $urandom_range(1, 6);
      base  = log_q.size();
      dwe0  = dwe_cnt;
      done0 = done_cnt;
      bad0  = bad_rst_cnt;
      cons0 = consec_cnt;
      for (int i = 0; i < 3; i++) send(addrs[i], dat[i], msk[i], i == 2);
      wait_rst_fall("t2");
      chk("t2_den_before_release", log_q.size() - base, 6);
      lock_done("t2");
      repeat (2) @(negedge CLK);
      chk("t2_den_count", log_q.size() - base, 6);
      chk("t2_dwe_count", dwe_cnt - dwe0, 3);
      chk("t2_den_without_rst", bad_rst_cnt - bad0, 0);
      chk("t2_den_back_to_back", consec_cnt - cons0, 0);
      chk("t2_done_pulses", done_cnt - done0, 1);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("t2_wr_addr%0d", i), log_q[base + 2*i + 1].addr, addrs[i]);
         chk($sformatf("t2_reg%0d", i), mem[addrs[i]], expv[i]);
      end

      // DRDY never returns on the read: timeout, release, no write, no done.
      never = 1;
      base  = log_q.size();
      dwe0  = dwe_cnt;
      done0 = done_cnt;
      send(7'h10, 16'($urandom), 16'($urandom), 1'b1);
      n = 0;
      while (error !== 1'b1 && n < 100) begin
         @(negedge CLK);
         n++;
      end
      t0 = $time;
      chk("t3_error_set", error, 1);
      chk("t3_one_read", log_q.size() - base, 1);
      chk("t3_error_cycle", 32'((t0 - log_q[base].t) / 10), 17);
      chk("t3_rst_released", mmcm_rst, 0);
      n = 0;
      while (busy !== 1'b0 && n < 200) begin
         @(negedge CLK);
         n++;
      end
      chk("t3_busy_clear", busy, 0);
      chk("t3_no_write", dwe_cnt - dwe0, 0);
      chk("t3_no_done", done_cnt - done0, 0);
      chk("t3_error_sticky", error, 1);
      never = 0;
      dat[0]  = 16'($urandom);
      msk[0]  = 16'($urandom);
      expv[0] = merge(mem[7'h11], dat[0], msk[0]);
      send(7'h11, dat[0], msk[0], 1'b1);
      chk("t3_error_cleared", error, 0);
      lock_done("t3");
      chk("t3_reg", mem[7'h11], expv[0]);

      // LOCKED held low: lock timeout sets error, clears busy, no done.
      done0   = done_cnt;
      dat[0]  = 16'($urandom);
      msk[0]  = 16'($urandom);
      expv[0] = merge(mem[7'h20], dat[0], msk[0]);
      send(7'h20, dat[0], msk[0], 1'b1);
      wait_rst_fall("t4");
      t0 = $time;
      n  = 0;
      while (busy !== 1'b0 && n < 200) begin
         @(negedge CLK);
         n++;
      end
      t1 = $time;
      chk("t4_busy_clear", busy, 0);
      chk("t4_error", error, 1);
      chk("t4_timeout_cycles", 32'((t1 - t0) / 10), 33);
      chk("t4_no_done", done_cnt - done0, 0);
      chk("t4_reg", mem[7'h20], expv[0]);

      // Spurious DRDY in IDLE, then during HOLD_RST.
      den0      = den_cnt;
      spur_drdy = 1'b1;
      repeat (3) @(negedge CLK);
      spur_drdy = 1'b0;
      @(negedge CLK);
      chk("t5_idle_no_den", den_cnt - den0, 0);
      chk("t5_idle_busy", busy, 0);
      chk("t5_idle_ready", req_ready, 1);
      chk("t5_idle_error_kept", error, 1);
      base    = log_q.size();
      dat[0]  = 16'($urandom);
      msk[0]  = 16'($urandom);
      expv[0] = merge(mem[7'h30], dat[0], msk[0]);
      send(7'h30, dat[0], msk[0], 1'b1);
      spur_drdy = 1'b1;
      repeat (2) @(negedge CLK);
      spur_drdy = 1'b0;
      lock_done("t5");
      chk("t5_hold_cycles", log_q[base].rst_run, HOLD);
      chk("t5_first_is_read", log_q[base].we, 0);
      chk("t5_den_count", log_q.size() - base, 2);
      chk("t5_reg", mem[7'h30], expv[0]);

      // Reset in WR_WAIT, then a fresh two-update batch.
      lat = 5;
      send(7'h40, 16'($urandom), 16'($urandom), 1'b1);
      n = 0;
      while (drp_dwe !== 1'b1 && n < 100) begin
         @(negedge CLK);
         n++;
      end
      chk("t6_write_seen", drp_dwe, 1);
      @(negedge CLK);
      #2 nRST = 1'b0;
      #1;
      chk_outputs_zero("t6_async");
      repeat (2) @(negedge CLK);
      nRST = 1'b1;
      @(negedge CLK);
      chk("t6_ready", req_ready, 1);
      lat   = $urandom_range(1, 6);
      done0 = done_cnt;
      addrs[0] = 7'h41;
      addrs[1] = 7'h7F;
      for (int i = 0; i < 2; i++) begin
         dat[i]  = 16'($urandom);
         msk[i]  = 16'($urandom);
         expv[i] = merge(mem[addrs[i]], dat[i], msk[i]);
      end
      for (int i = 0; i < 2; i++) send(addrs[i], dat[i], msk[i], i == 1);
      lock_done("t6");
      chk("t6_done_pulses", done_cnt - done0, 1);
      chk("t6_reg0", mem[addrs[0]], expv[0]);
      chk("t6_reg1", mem[addrs[1]], expv[1]);
      chk("t6_error", error, 0);

      chk("all_den_with_rst", bad_rst_cnt, 0);
      chk("all_den_spacing", consec_cnt, 0);
      chk("all_dwe_needs_den", dwe_alone_cnt, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/mmcm_drp_reconfig.md
Name: mmcm_drp_reconfig

Overview:
- Master for the MMCM dynamic reconfiguration port (DRP), which the clock-generation top currently ties off.
- Accepts a stream of masked register updates from a control block and performs one DRP read-modify-write per update.
- Holds the MMCM in reset for the whole batch, then releases it and waits for LOCKED before reporting done.
- DCLK is driven from CLK at the instantiating level; this block has one clock.

Parameters:
- DRDY_TIMEOUT, 255, max cycles to wait for drp_drdy after drp_den before error.
- LOCK_TIMEOUT, 65535, max cycles to wait for synchronized LOCKED after reset release.
- RST_HOLD, 4, cycles mmcm_rst is held asserted before the first DRP access.

Ports:
- CLK  in  1  clock; also DRP DCLK.
- nRST  in  1  asynchronous, active-low reset.
- req_valid  in  1  update request valid.
- req_ready  out  1  request accepted when valid&&ready.
- req_addr  in  7  DRP register address.
- req_data  in  16  new bit values.
- req_mask  in  16  1 = keep the readback bit; 0 = take the req_data bit.
- req_last  in  1  final update of the batch.
- drp_daddr  out  7  to MMCM DADDR.
- drp_den  out  1  to MMCM DEN.
- drp_dwe  out  1  to MMCM DWE.
- drp_di  out  16  to MMCM DI.
- drp_do  in  16  from MMCM DO.
- drp_drdy  in  1  from MMCM DRDY.
- mmcm_rst  out  1  to MMCM RST (active-high).
- mmcm_locked  in  1  MMCM LOCKED (asynchronous to CLK).
- busy  out  1  batch in progress.
- done  out  1  one-cycle pulse: batch complete and lock achieved.
- error  out  1  sticky; cleared by the next accepted request.

Behaviour:
- Reset values: req_ready=0, drp_daddr=0, drp_den=0, drp_dwe=0, drp_di=0, mmcm_rst=0, busy=0, done=0, error=0. FSM enters IDLE.
- FSM states: IDLE, HOLD_RST, RD, RD_WAIT, WR, WR_WAIT, NEXT, RELEASE, WAIT_LOCK.
- IDLE:
  - req_ready=1.
  - On accept, latch addr/data/mask/last, clear error, set busy=1, mmcm_rst=1, load counter with RST_HOLD-1, go to HOLD_RST.
- HOLD_RST: count down; at 0 go to RD.
- RD: drp_den=1 and drp_dwe=0 for exactly one cycle, drp_daddr=latched addr; load timeout counter; go to RD_WAIT.
- RD_WAIT:
  - On drp_drdy, compute drp_di = (drp_do & mask) | (data & ~mask), registered, then go to WR.
  - If the counter expires, go to RELEASE with error=1.
- WR: drp_den=1 and drp_dwe=1 for one cycle with drp_di stable; go to WR_WAIT.
- WR_WAIT:
  - On drp_drdy, go to NEXT if latched last=0, otherwise RELEASE.
  - Timeout is handled as in RD_WAIT.
- NEXT:
  - req_ready=1; mmcm_rst stays 1.
  - On accept, latch the new request and go to RD. No HOLD_RST repeat within a batch.
  - Waits indefinitely for the next request.
- RELEASE: mmcm_rst=0; load LOCK_TIMEOUT; go to WAIT_LOCK.
- WAIT_LOCK:
  - On synchronized locked=1: done pulses 1 cycle, busy=0, go to IDLE.
  - On timeout: error=1, busy=0, no done pulse, go to IDLE.
- drp_daddr and drp_di hold their values until the next DRP access; drp_dwe is 0 whenever drp_den is 0.
- drp_drdy outside RD_WAIT/WR_WAIT is ignored. drp_drdy in the same cycle as drp_den is invalid per the DRP protocol; it is ignored.
- Never more than one DRP access outstanding; drp_den is never asserted in consecutive cycles.
- mmcm_locked passes through a 2-flop synchronizer (reset to 0). Latency is 2 cycles.
- Counters are sized with $clog2(param+1). Timeout fires when the counter reaches 0 while waiting, after param+1 wait cycles.
- Reset mid-operation:
  - Outputs return to reset values immediately (asynchronous), including mmcm_rst=0.
  - A partially written MMCM configuration is the caller's responsibility.

Decomposition:
- Package mmcm_drp_pkg:
  - state enum drp_state_t.
  - DRP_ADDR_W=7 and DRP_DATA_W=16.
  - Function rmw(do, data, mask).
- Sub-module sync2: 2-flop synchronizer, async active-low reset, reset value parameterized. Used for mmcm_locked.

Test Plan:
- Single request {addr=0x08, data=0x1234, mask=0xF000, last=1}, DO=0xABCD, DRDY 3 cycles after each DEN:
  - mmcm_rst=1 for ≥4 cycles before the first DEN.
  - Read at 0x08, then write at 0x08 with DI=0xA234.
  - mmcm_rst falls; LOCKED raised → done pulses 2 cycles later; busy=0.
- Batch of 3 requests (addr 0x08, 0x09, 0x4E), last on the third:
  - Exactly 6 DEN pulses, 3 with DWE=1.
  - mmcm_rst stays high throughout and releases only after the third write.
  - One done pulse.
- DRDY never returns on the read with DRDY_TIMEOUT=15:
  - error=1 after 16 wait cycles; mmcm_rst released; no write issued; no done.
  - The next request clears error.
- LOCKED held low with LOCK_TIMEOUT=31: error=1 and busy=0 at timeout; no done pulse.
- Spurious drp_drdy in IDLE and in HOLD_RST: no state change, no DEN.
- nRST asserted during WR_WAIT:
  - All outputs 0 immediately, including mmcm_rst.
  - After deassert: req_ready=1 and a fresh batch completes normally.
